// File: rtl/operand_loader_pkg.sv
// Shared types and sizing helpers for the operand loader and its ping-pong banks.
package operand_loader_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } bank_state_e;

  // Index width for a frame of n samples; never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DefaultArraySize = 8;
  localparam int unsigned DefaultIdxW      = idx_width(DefaultArraySize);

endpackage

// File: rtl/operand_bank.sv
// One frame buffer of the ping-pong pair: sample storage, fill state and zero-fill on release.
module operand_bank
  import operand_loader_pkg::*;
#(
  parameter int unsigned INPUT_BW   = 8,
  parameter int unsigned ARRAY_SIZE = 8,
  localparam int unsigned IdxW      = idx_width(ARRAY_SIZE)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_wr_en,
  input  logic [IdxW-1:0]                      i_wr_idx,
  input  logic [INPUT_BW-1:0]                  i_wr_data,
  input  logic                                 i_wr_last,
  input  logic                                 i_rd_take,
  output bank_state_e                          o_state,
  output logic [ARRAY_SIZE-1:0][INPUT_BW-1:0]  o_data
);

  bank_state_e                         r_state;
  bank_state_e                         w_state_next;
  logic [ARRAY_SIZE-1:0][INPUT_BW-1:0] r_data;
  logic                                w_wr;
  logic                                w_take;

  assign w_wr   = i_wr_en && (r_state != FULL);
  assign w_take = i_rd_take && (r_state == FULL);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      EMPTY, FILLING: begin
        if (w_wr) w_state_next = i_wr_last ? FULL : FILLING;
      end
      FULL: begin
        if (w_take) w_state_next = EMPTY;
      end
      default: w_state_next = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Clearing on release means a short frame written later finds zeros above its last slot.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data <= '0;
    end else if (w_take) begin
      r_data <= '0;
    end else if (w_wr) begin
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_state = r_state;
  assign o_data  = r_data;

endmodule

// File: rtl/operand_loader.sv
// Serial-to-parallel ping-pong loader feeding registered frames to the adder tree.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int unsigned INPUT_BW   = 8,
  parameter int unsigned ARRAY_SIZE = 8
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [INPUT_BW-1:0]                  i_in_data,
  input  logic                                 i_in_valid,
  input  logic                                 i_in_last,
  output logic                                 o_in_ready,
  output logic [ARRAY_SIZE-1:0][INPUT_BW-1:0]  o_operands,
  output logic                                 o_out_valid,
  input  logic                                 i_out_ready
);

  localparam int unsigned IdxW = idx_width(ARRAY_SIZE);

  logic                                r_wr_bank;
  logic                                r_rd_bank;
  logic [IdxW-1:0]                     r_wr_idx;
  logic                                w_wr_bank_next;
  logic                                w_rd_bank_next;
  logic [IdxW-1:0]                     w_wr_idx_next;

  bank_state_e                         w_state0;
  bank_state_e                         w_state1;
  logic [ARRAY_SIZE-1:0][INPUT_BW-1:0] w_data0;
  logic [ARRAY_SIZE-1:0][INPUT_BW-1:0] w_data1;

  logic w_in_ready;
  logic w_out_valid;
  logic w_in_hs;
  logic w_out_hs;
  logic w_complete;

  // Ready and valid come from bank state registers only.
  assign w_in_ready  = r_wr_bank ? (w_state1 != FULL) : (w_state0 != FULL);
  assign w_out_valid = r_rd_bank ? (w_state1 == FULL) : (w_state0 == FULL);
  assign w_in_hs     = i_in_valid && w_in_ready;
  assign w_out_hs    = w_out_valid && i_out_ready;
  assign w_complete  = i_in_last || (r_wr_idx == IdxW'(ARRAY_SIZE - 1));

  always_comb begin
    w_wr_bank_next = r_wr_bank;
    w_rd_bank_next = r_rd_bank;
    w_wr_idx_next  = r_wr_idx;
    if (w_in_hs) begin
      if (w_complete) begin
        w_wr_idx_next  = '0;
        w_wr_bank_next = ~r_wr_bank;
      end else begin
        w_wr_idx_next = r_wr_idx + IdxW'(1);
      end
    end
    if (w_out_hs) w_rd_bank_next = ~r_rd_bank;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_idx  <= '0;
    end else begin
      r_wr_bank <= w_wr_bank_next;
      r_rd_bank <= w_rd_bank_next;
      r_wr_idx  <= w_wr_idx_next;
    end
  end

  operand_bank #(
    .INPUT_BW  (INPUT_BW),
    .ARRAY_SIZE(ARRAY_SIZE)
  ) u_bank0 (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_wr_en  (w_in_hs && !r_wr_bank),
    .i_wr_idx (r_wr_idx),
    .i_wr_data(i_in_data),
    .i_wr_last(w_complete),
    .i_rd_take(w_out_hs && !r_rd_bank),
    .o_state  (w_state0),
    .o_data   (w_data0)
  );

  operand_bank #(
    .INPUT_BW  (INPUT_BW),
    .ARRAY_SIZE(ARRAY_SIZE)
  ) u_bank1 (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_wr_en  (w_in_hs && r_wr_bank),
    .i_wr_idx (r_wr_idx),
    .i_wr_data(i_in_data),
    .i_wr_last(w_complete),
    .i_rd_take(w_out_hs && r_rd_bank),
    .o_state  (w_state1),
    .o_data   (w_data1)
  );

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = w_out_valid;
  assign o_operands  = r_rd_bank ? w_data1 : w_data0;

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: directed frames queued as expectations, monitor pops on take.
module tb_operand_loader;

  typedef logic [7:0][7:0] frame_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  frame_t     operands;
  logic       out_valid;
  logic       out_ready;

  int     n_vec  = 0;
  int     n_fail = 0;
  frame_t sb[$];
  frame_t mon_exp;

  operand_loader #(
    .INPUT_BW  (8),
    .ARRAY_SIZE(8)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_in_data  (in_data),
    .i_in_valid (in_valid),
    .i_in_last  (in_last),
    .o_in_ready (in_ready),
    .o_operands (operands),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic frame_t mk(input int base, input int n);
    frame_t f;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < n) f[i] = 8'(base + i);
    end
    return f;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkf(input string name, input frame_t act, input frame_t exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor samples mid-low-phase, after the negedge-driven inputs have settled.
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got frame %h expected none", operands);
      end else begin
        mon_exp = sb.pop_front();
        if (operands !== mon_exp) begin
          n_fail++;
          $display("FAIL sb_frame: got %h expected %h", operands, mon_exp);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the sample is accepted.
  task automatic send(input int d, input bit last);
    int cyc;
    cyc      = 0;
    in_data  = 8'(d);
    in_valid = 1'b1;
    in_last  = last;
    while (!in_ready && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    if (!in_ready) begin
      n_vec++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 for sample %0d", d);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    cyc       = 0;
    out_ready = 1'b1;
    while ((out_valid || sb.size() != 0) && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    n_vec++;
    if (out_valid || sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending frames expected 0", sb.size());
    end
  endtask

  initial begin
    int sum;
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chkf("rst_operands", operands, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Stream 1..8 with consumer ready
    out_ready = 1'b1;
    sb.push_back(mk(1, 8));
    for (int d = 1; d <= 7; d++) send(d, 1'b0);
    chk1("s1_valid_before_last", out_valid, 1'b0);
    send(8, 1'b0);
    chk1("s1_valid_latency", out_valid, 1'b1);
    chkf("s1_operands", operands, mk(1, 8));
    sum = 0;
    for (int i = 0; i < 8; i++) sum += int'($signed(operands[i]));
    n_vec++;
    if (sum != 36) begin
      n_fail++;
      $display("FAIL s1_tree_sum: got %0d expected 36", sum);
    end
    @(negedge clk);
    chk1("s1_valid_after_take", out_valid, 1'b0);

    // Backpressure: -8..7 fill both banks, 8 is held
    out_ready = 1'b0;
    sb.push_back(mk(-8, 8));
    sb.push_back(mk(0, 8));
    for (int d = -8; d <= 7; d++) send(d, 1'b0);
    chk1("bp_in_ready_low", in_ready, 1'b0);
    in_data  = 8'd8;
    in_valid = 1'b1;
    in_last  = 1'b1;
    repeat (3) @(negedge clk);
    chk1("bp_held_valid", out_valid, 1'b1);
    chkf("bp_held_operands", operands, mk(-8, 8));
    chk1("bp_still_blocked", in_ready, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chkf("bp_switch_operands", operands, mk(0, 8));
    chk1("bp_in_ready_back", in_ready, 1'b1);
    sb.push_back(mk(8, 1));
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk1("bp_after_8_blocked", in_ready, 1'b0);
    drain();

    // Early end onto banks previously holding 0x55
    sb.push_back(mk(8'h55, 1) | {8{8'h55}});
    sb.push_back({8{8'h55}});
    sb.push_back({8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hff, 8'h7f, 8'h80});
    for (int i = 0; i < 16; i++) send(8'h55, 1'b0);
    send(-128, 1'b0);
    send(127, 1'b0);
    send(-1, 1'b1);
    chk1("early_valid", out_valid, 1'b1);
    chkf("early_operands", operands, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hff, 8'h7f, 8'h80});
    drain();

    // Reset mid-frame
    for (int d = 10; d <= 14; d++) send(d, 1'b0);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chk1("mid_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(mk(10, 8));
    for (int d = 10; d <= 17; d++) send(d, 1'b0);
    chkf("mid_rst_frame", operands, mk(10, 8));
    drain();

    // Simultaneous handshakes with both banks full
    out_ready = 1'b0;
    sb.push_back(mk(20, 8));
    sb.push_back(mk(30, 8));
    sb.push_back(mk(99, 1));
    for (int d = 20; d <= 27; d++) send(d, 1'b0);
    for (int d = 30; d <= 37; d++) send(d, 1'b0);
    chk1("sim_full_blocked", in_ready, 1'b0);
    in_data   = 8'd99;
    in_valid  = 1'b1;
    in_last   = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk1("sim_in_ready_next", in_ready, 1'b1);
    chk1("sim_no_gap", out_valid, 1'b1);
    chkf("sim_second_frame", operands, mk(30, 8));
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk1("sim_99_valid", out_valid, 1'b1);
    chkf("sim_99_frame", operands, mk(99, 1));
    drain();

    n_vec++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d frames expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
# operand_loader

Serial-to-parallel operand buffer that sits upstream of the combinational adder tree in the 1-D datapath. It accepts one signed sample per cycle over a valid/ready stream and packs samples into ARRAY_SIZE-wide frames. Each completed frame is presented, fully registered, on the `operands` array that the adder tree consumes. Two ping-pong banks let the next frame fill while the current one is held.

## Interface
- `INPUT_BW`, 8: sample width, signed two's complement.
- `ARRAY_SIZE`, 8: samples per frame; power of two, ≥2, matching the adder tree width.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `in_data`  in  INPUT_BW  signed sample.
- `in_valid`  in  1  `in_data` is valid.
- `in_last`  in  1  this sample ends the frame early; sampled only on input handshake.
- `in_ready`  out  1  loader can accept a sample.
- `operands`  out  INPUT_BW × [ARRAY_SIZE-1:0]  frame presented to the adder tree; slot 0 holds the first sample.
- `out_valid`  out  1  `operands` holds a complete frame.
- `out_ready`  in  1  consumer takes the frame.

## Operation
- Input handshake: `in_valid && in_ready` at a rising edge. Output handshake: `out_valid && out_ready`.
- Per-bank state is EMPTY, FILLING or FULL.
  - EMPTY→FILLING on the first accepted sample.
  - FILLING→FULL on the sample written to index ARRAY_SIZE-1, or on any sample with `in_last`=1.
  - FULL→EMPTY on output handshake.
  - A one-sample frame (`in_last` on its first sample) goes EMPTY→FULL directly.
- Write side: `wr_bank` and `wr_idx` (clog2(ARRAY_SIZE) bits). Each accepted sample is stored at `bank[wr_bank][wr_idx]`. On frame completion `wr_idx`→0 and `wr_bank` toggles; otherwise `wr_idx` increments.
- Zero-fill: when a frame completes via `in_last` at index k, slots k+1..ARRAY_SIZE-1 of that bank read as 0 in the presented frame. Stale data from earlier frames never appears.
- Read side: `rd_bank`. `operands` = `bank[rd_bank]`. `out_valid` = `rd_bank` is FULL. An output handshake sets that bank to EMPTY and toggles `rd_bank`.
- `in_ready` = `wr_bank` is not FULL. It depends only on registers; there is no combinational path from `out_ready` or `in_valid` to any output.
- `in_last` without a handshake is ignored. `in_data` is passed through as-is; there is no arithmetic and no width change.
- Simultaneous input and output handshakes on different banks are both honoured in the same cycle.
- When both banks are FULL, `wr_bank == rd_bank` and `in_ready`=0. An output handshake in that cycle frees the bank; `in_ready` rises the next cycle.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - `in_ready`=1, `out_valid`=0, all `operands` slots 0.
  - Both banks EMPTY and cleared; `wr_bank`=`rd_bank`=0; `wr_idx`=0.
- Reset mid-frame discards all partial and full frames. The first sample after release goes to bank 0, slot 0.
- Latency: the completing sample is accepted at edge t; `out_valid`=1 and the frame appears on `operands` after edge t (cycle t+1).
- `operands` is stable while `out_valid`=1 and `out_ready`=0.
- Throughput: one sample per cycle, sustained, provided each frame is taken within ARRAY_SIZE cycles of presentation.
- After both banks fill, at most 2·ARRAY_SIZE samples are accepted before `in_ready` drops.

## Structure
- Package `operand_loader_pkg`:
  - `typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_e`.
  - Index-width localparam helper based on clog2(ARRAY_SIZE).
- Sub-module `operand_bank`, instantiated twice. It holds one register array, its `bank_state_e`, a write port (index, data, last) and the zero-fill logic.
- Top level holds `wr_bank`, `rd_bank`, `wr_idx` and the handshake logic.

## Test plan
Defaults INPUT_BW=8, ARRAY_SIZE=8.
- Reset: hold `rst_n`=0 → `in_ready`=1, `out_valid`=0, all `operands`=0.
- Stream 1..8 back-to-back with `out_ready`=1 → `out_valid` one cycle after the 8th acceptance; `operands[0..7]`=1..8; downstream tree sum=36; next frame starts at slot 0.
- Backpressure: `out_ready`=0, offer -8..8 continuously.
  - -8..7 are accepted; `in_ready` drops after 7 is accepted; 8 is held.
  - Pulse `out_ready` → frame -8..-1 is taken, `operands` switches to 0..7, `in_ready`=1 the next cycle, and 8 is accepted.
- Early end: samples -128, 127, -1 with `in_last` on -1 → `operands`=-128, 127, -1, 0, 0, 0, 0, 0 after a prior frame of all 0x55.
- Reset mid-frame: after 5 of 8 samples, pulse `rst_n` low → `out_valid`=0, `in_ready`=1. The next 8 samples 10..17 form one clean frame 10..17.
- Simultaneous: with both banks FULL, assert `out_ready` and `in_valid` together.
  - The sample is not accepted that cycle; `in_ready`=1 the next cycle.
  - The second frame is presented with no gap cycle.
